// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ill_cnt
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;

    logic             main_valid, skid_valid;
    logic [XLEN-1:0]  main_imm, skid_imm;
    logic [2:0]       main_fmt, skid_fmt;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             accept, pop;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'($signed(inst[31:20]));
            end
            7'b0010011: begin
                dec_fmt = FMT_I;
                // Shift immediates exclude funct7 and are never sign-extended.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
                else
                    dec_imm = XLEN'($signed(inst[31:20]));
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed({inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            7'b0110011: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_fmt = FMT_ILL;
            end
        endcase
    end

    // in_ready comes straight from the skid valid flop: room exists unless skid is occupied.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready;
    assign out_valid = main_valid;
    assign imm       = main_imm;
    assign fmt       = main_fmt;
    assign out_tag   = main_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_imm   <= '0;
            main_fmt   <= '0;
            main_tag   <= '0;
            skid_imm   <= '0;
            skid_fmt   <= '0;
            skid_tag   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop && skid_valid) begin
            main_imm   <= skid_imm;
            main_fmt   <= skid_fmt;
            main_tag   <= skid_tag;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || pop)) begin
            main_valid <= 1'b1;
            main_imm   <= dec_imm;
            main_fmt   <= dec_fmt;
            main_tag   <= in_tag;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_tag   <= in_tag;
        end else if (pop) begin
            main_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ill_cnt <= '0;
        else if (!flush && accept && dec_fmt == FMT_ILL && ill_cnt != {CNT_W{1'b1}})
            ill_cnt <= ill_cnt + 1'b1;
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN=64, CNT_W=2)
module tb_imm_gen_pipe;
    localparam int XLEN  = 64;
    localparam int TAG_W = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      inst = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] ill_cnt;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .out_tag(out_tag), .ill_cnt(ill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
    } item_t;

    item_t q[$];
    int    m_cnt = 0;
    bit    started = 0;
    int    n_pass = 0;
    int    n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, want);
    endtask

    // Immediate value computed as a signed integer from the field layout of each format.
    function automatic item_t model(input logic [31:0] w, input logic [31:0] t);
        item_t  r;
        longint v;
        v = 0;
        r.fmt = 3'd7;
        case (w[6:0])
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011, 7'b0010011: begin
                r.fmt = 3'd1;
                if (w[6:0] == 7'b0010011 && (w[14:12] == 3'b001 || w[14:12] == 3'b101))
                    v = w[25:20];
                else begin
                    v = w[31:20];
                    if (v >= 2048) v -= 4096;
                end
            end
            7'b0100011: begin
                r.fmt = 3'd2;
                v = {w[31:25], w[11:7]};
                if (v >= 2048) v -= 4096;
            end
            7'b1100011: begin
                r.fmt = 3'd3;
                v = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                if (v >= 4096) v -= 8192;
            end
            7'b0110111, 7'b0010111: begin
                r.fmt = 3'd4;
                v = longint'(w[31:12]) * 4096;
                if (w[31]) v -= 64'h1_0000_0000;
            end
            7'b1101111: begin
                r.fmt = 3'd5;
                v = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            7'b0110011: r.fmt = 3'd0;
            default:    r.fmt = 3'd7;
        endcase
        r.imm = 64'(v);
        r.tag = t;
        return r;
    endfunction

    always @(posedge clk) begin
        bit acc, pp;
        item_t it;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            if (pp) void'(q.pop_front());
            if (acc) begin
                it = model(inst, in_tag);
                q.push_back(it);
                if (it.fmt == 3'd7 && m_cnt < 3) m_cnt++;
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("ill_cnt", 64'(ill_cnt), 64'(m_cnt));
            if (q.size() > 0) begin
                check("imm", imm, q[0].imm);
                check("fmt", 64'(fmt), 64'(q[0].fmt));
                check("out_tag", 64'(out_tag), 64'(q[0].tag));
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the input deasserted.
    task automatic issue(input logic [31:0] w, input logic [31:0] t);
        in_valid = 1'b1;
        inst     = w;
        in_tag   = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst imm", imm, 64'd0);
        check("rst fmt", 64'(fmt), 64'd0);
        check("rst out_tag", 64'(out_tag), 64'd0);
        check("rst ill_cnt", 64'(ill_cnt), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        issue(32'hFE000EE3, 32'h100);
        check("beq imm", imm, 64'hFFFFFFFFFFFFFFFC);
        check("beq fmt", 64'(fmt), 64'd3);
        check("beq tag", 64'(out_tag), 64'h100);
        issue(32'h800000B7, 32'h104);
        check("lui neg imm", imm, 64'hFFFFFFFF80000000);
        check("lui fmt", 64'(fmt), 64'd4);
        issue(32'h123450B7, 32'h108);
        check("lui pos imm", imm, 64'h0000000012345000);
        issue(32'h4030D093, 32'h10C);
        check("srai imm", imm, 64'd3);
        check("srai fmt", 64'(fmt), 64'd1);
        issue(32'h0010006F, 32'h110);
        check("jal imm", imm, 64'h800);
        check("jal fmt", 64'(fmt), 64'd5);
        issue(32'h00A12623, 32'h114);
        issue(32'h002081B3, 32'h118);
        check("add fmt", 64'(fmt), 64'd0);
        check("add imm", imm, 64'd0);
        @(negedge clk);

        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h00100093; in_tag = 32'hA0;
        @(negedge clk);
        check("bp ready1", 64'(in_ready), 64'd1);
        inst = 32'h00200093; in_tag = 32'hA1;
        @(negedge clk);
        check("bp ready full", 64'(in_ready), 64'd0);
        inst = 32'h00300093; in_tag = 32'hA2;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp head tag", 64'(out_tag), 64'hA0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp second tag", 64'(out_tag), 64'hA1);
        check("bp ready back", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("bp drained", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        issue(32'h00100093, 32'hB0);
        issue(32'h00200093, 32'hB1);
        in_valid = 1'b1; inst = 32'h0000007F; in_tag = 32'hB2; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush no count", 64'(ill_cnt), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            issue(32'h0000007F, 32'hC0 + i);
            check("ill fmt", 64'(fmt), 64'd7);
            check("ill imm", imm, 64'd0);
        end
        @(negedge clk);
        check("ill_cnt 3", 64'(ill_cnt), 64'd3);
        issue(32'h0000007F, 32'hC3);
        @(negedge clk);
        check("ill_cnt sat", 64'(ill_cnt), 64'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("ill_cnt after flush", 64'(ill_cnt), 64'd3);
        issue(32'hFE000EE3, 32'hD0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2 ill_cnt", 64'(ill_cnt), 64'd0);
        check("rst2 out_valid", 64'(out_valid), 64'd0);
        check("rst2 imm", imm, 64'd0);
        check("rst2 out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, plus shift-amount and R-type), reports the detected format, and flags illegal opcodes. A 2-entry skid buffer with a valid/ready handshake gives full throughput under back-pressure. The block sits between the fetch/IF-ID register and the register-file read / ID-EX register, and supports a synchronous flush for branch redirects.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each instruction.
- CNT_W, 16, width of the saturating illegal-instruction counter.

- clk  in  1  rising-edge clock; the block uses one clock only.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill; empties both entries.
- in_valid  in  1  an instruction is present on inst/in_tag.
- in_ready  out  1  the block can accept an instruction this cycle (driven from a register).
- inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  an entry is present on the outputs.
- out_ready  in  1  the consumer accepts the entry this cycle.
- imm  out  XLEN  sign- or zero-extended immediate.
- fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_tag  out  TAG_W  tag of the entry on the outputs.
- ill_cnt  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- **Format decode from opcode inst[6:0]:**
  - 0000011, 0010011, 1100111, 0001111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → R.
  - Any other opcode → ILL.
- **Immediate construction:**
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sext({inst[31:12], 12'b0}). With XLEN=64, bits 63:32 copy inst[31].
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R and ILL: 0.
  - Shift exception: opcode 0010011 with funct3 001 or 101 yields zero-extended inst[24:20] when XLEN=32, or inst[25:20] when XLEN=64. funct7 is excluded from imm.
- **Decode point:** the immediate and format are computed combinationally at the input and registered on acceptance.
- **Storage:** two entries, main (drives the outputs) and skid.
  - Accept: in_valid && in_ready.
  - Pop: out_valid && out_ready.
  - Accept while main is empty, or while main is popped in the same cycle → the entry goes to main.
  - Accept while main holds an entry and is not popped → the entry goes to skid; in_ready drops to 0 the next cycle.
  - Pop while skid is valid → skid moves to main; in_ready returns to 1 the next cycle.
  - Order is strictly FIFO.
- **Illegal counter:** ill_cnt increments by 1 on each accepted entry with fmt=ILL and saturates at 2^CNT_W−1. flush does not clear it; rst does.
- **Flush:** clears both entry valids. Flush has priority over a same-cycle accept, so that input is dropped and not counted. A same-cycle pop is ignored by the consumer.

## Timing
- **Reset values:** out_valid=0, in_ready=1, imm=0, fmt=0, out_tag=0, ill_cnt=0, skid valid=0.
- **Latency:** an instruction accepted at edge N is on the outputs with out_valid=1 from edge N onward, i.e. one register stage.
- **Throughput:** one instruction per cycle while out_ready=1.
- **Flow-control rules:**
  - in_ready is a registered signal and never combinationally depends on out_ready.
  - out_valid never drops until the entry is popped or flushed.
  - Output data is stable while out_valid=1 && out_ready=0.
- **Full condition:** with both entries valid, in_ready=0 and inputs are ignored.
- **Empty pop:** a pop while out_valid=0 has no effect.
- **Simultaneous accept and pop:** with one entry valid, the new entry replaces main; occupancy is unchanged.
- **Reset vs. flush:** rst mid-operation behaves like flush and additionally clears ill_cnt and the output registers.

## Test plan
- **B-format:** inst=0xFE000EE3 (beq x0,x0,-4), out_ready=1 → next cycle imm=0xFFFFFFFC, fmt=3, out_tag equals in_tag.
- **U-format, XLEN=64:** inst=0x800000B7 → imm=0xFFFFFFFF80000000, fmt=4. inst=0x123450B7 → imm=0x0000000012345000.
- **Shift and J-format:** inst=0x4030D093 (srai x1,x1,3) → imm=3, fmt=1. inst=0x0010006F (jal +2048) → imm=0x00000800, fmt=5.
- **Back-pressure:**
  - Hold out_ready=0 and offer 3 instructions back-to-back → 2 accepted, in_ready=0 on the third cycle.
  - Raise out_ready → outputs appear in the original order, then in_ready=1.
- **Flush:** with 2 entries held, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
- **Illegal counter:** feed inst=0x0000007F 3 times → fmt=7, imm=0, ill_cnt=3. With CNT_W=2, a 4th illegal instruction leaves ill_cnt=3. A flush keeps the count; rst clears it to 0.
